// File: rtl/pipe_mem_stall_ctrl.sv
// pipe_mem_stall_ctrl: pipeline enable/flush sequencer with data-memory handshake, hazard stalls and stall counter
module pipe_mem_stall_ctrl #(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             MemRead_M,
   input  logic             MemWrite_M,
   input  logic             mem_ack,
   input  logic             MemRead_E,
   input  logic [4:0]       Rd_E,
   input  logic [4:0]       Rs1_D,
   input  logic [4:0]       Rs2_D,
   input  logic             PCSrc_E,
   input  logic             err_clr,
   output logic             mem_req,
   output logic             en_PC,
   output logic             en_FD,
   output logic             en_DE,
   output logic             en_EM,
   output logic             en_MW,
   output logic             flush_FD,
   output logic             flush_DE,
   output logic             flush_MW,
   output logic             mem_busy,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] LAST = WW'(MAX_WAIT - 1);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t state;
   logic [WW-1:0] wait_cnt;
   logic memop, tmo, rel, ms, lu, run, br, st;
   // Mealy control: memory stall beats branch flush beats load-use; everything low while in reset
   always_comb begin
      memop    = MemRead_M | MemWrite_M;
      mem_req  = ~rst & ((state == IDLE & memop) | state == WAIT);
      tmo      = state == WAIT & wait_cnt == LAST;
      rel      = mem_req & (mem_ack | tmo);
      ms       = mem_req & ~rel;
      lu       = MemRead_E & (Rd_E != 5'd0) & (Rd_E == Rs1_D | Rd_E == Rs2_D);
      run      = ~rst & ~ms;
      br       = run & PCSrc_E;
      st       = run & ~PCSrc_E & lu;
      en_PC    = run & ~st;
      en_FD    = run & ~st;
      en_DE    = run;
      en_EM    = run;
      en_MW    = ~rst;
      flush_FD = br;
      flush_DE = br | st;
      flush_MW = ~rst & ms;
      mem_busy = state == WAIT;
   end
   // Handshake state, timeout counter, sticky error (set beats clear) and stall counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         mem_err   <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state     <= (state == IDLE) ? ((memop & ~mem_ack) ? WAIT : IDLE) : (rel ? IDLE : WAIT);
         wait_cnt  <= (state == IDLE) ? '0 : wait_cnt + WW'(1);
         mem_err   <= (tmo & ~mem_ack) | (mem_err & ~err_clr);
         stall_cnt <= stall_cnt + CNT_W'(!en_PC);
      end
   end
endmodule

// File: tb/tb_pipe_mem_stall_ctrl.sv
// tb_pipe_mem_stall_ctrl: scoreboard bench for the pipeline stall/flush sequencer
module tb_pipe_mem_stall_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic MemRead_M = 0, MemWrite_M = 0, mem_ack = 0, MemRead_E = 0, PCSrc_E = 0, err_clr = 0;
   logic [4:0] Rd_E = 0, Rs1_D = 0, Rs2_D = 0;
   logic mem_req, en_PC, en_FD, en_DE, en_EM, en_MW, flush_FD, flush_DE, flush_MW, mem_busy, mem_err;
   logic [31:0] stall_cnt;
   logic [10:0] ctl_o;

   pipe_mem_stall_ctrl #(.MAX_WAIT(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M), .mem_ack(mem_ack),
      .MemRead_E(MemRead_E), .Rd_E(Rd_E), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .PCSrc_E(PCSrc_E),
      .err_clr(err_clr), .mem_req(mem_req), .en_PC(en_PC), .en_FD(en_FD), .en_DE(en_DE),
      .en_EM(en_EM), .en_MW(en_MW), .flush_FD(flush_FD), .flush_DE(flush_DE), .flush_MW(flush_MW),
      .mem_busy(mem_busy), .mem_err(mem_err), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   assign ctl_o = {mem_req, en_PC, en_FD, en_DE, en_EM, en_MW, flush_FD, flush_DE, flush_MW, mem_busy, mem_err};

   // {mem_req, en_PC,en_FD,en_DE,en_EM,en_MW, flush_FD,flush_DE,flush_MW, mem_busy, mem_err}
   localparam logic [10:0] RST0 = 11'b0_00000_000_0_0;
   localparam logic [10:0] RUN  = 11'b0_11111_000_0_0;
   localparam logic [10:0] MSI  = 11'b1_00001_001_0_0;
   localparam logic [10:0] MSW  = 11'b1_00001_001_1_0;
   localparam logic [10:0] RLI  = 11'b1_11111_000_0_0;
   localparam logic [10:0] RLW  = 11'b1_11111_000_1_0;
   localparam logic [10:0] LU   = 11'b0_00111_010_0_0;
   localparam logic [10:0] BR   = 11'b0_11111_110_0_0;
   localparam logic [10:0] BRW  = 11'b1_11111_110_1_0;

   typedef struct packed {
      logic mrm, mwm, ack, clr, r, mre;
      logic [4:0] rd, rs1, rs2;
      logic pc;
   } stim_t;

   typedef struct {
      string       name;
      logic [10:0] ctl;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];
   int passed = 0;
   int total = 0;
   logic [31:0] exp_cnt = 0;
   logic exp_err = 0;

   function automatic stim_t S(logic mrm = 0, logic mwm = 0, logic ack = 0, logic clr = 0, logic r = 0,
                               logic mre = 0, logic [4:0] rd = 0, logic [4:0] rs1 = 0,
                               logic [4:0] rs2 = 0, logic pc = 0);
      stim_t s;
      s.mrm = mrm; s.mwm = mwm; s.ack = ack; s.clr = clr; s.r = r;
      s.mre = mre; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.pc = pc;
      return s;
   endfunction

   // applies one cycle of stimulus at the falling edge and queues what the outputs must be
   task automatic drive(input stim_t s, input logic [10:0] ctl, input string name);
      exp_t e;
      @(negedge clk);
      rst = s.r; MemRead_M = s.mrm; MemWrite_M = s.mwm; mem_ack = s.ack; err_clr = s.clr;
      MemRead_E = s.mre; Rd_E = s.rd; Rs1_D = s.rs1; Rs2_D = s.rs2; PCSrc_E = s.pc;
      if (s.r) begin
         exp_cnt = 0;
         exp_err = 0;
      end
      e.name = name;
      e.ctl  = ctl | {10'b0, exp_err};
      e.cnt  = exp_cnt;
      sb.push_back(e);
      if (!s.r && !ctl[9]) exp_cnt++;
      #2;
   endtask

   task automatic test_reset();
      stim_t t[$];
      logic [10:0] x[$];
      t = '{S(0, 0, 0, 0, 1), S(1, 0, 0, 0, 1), S()};
      x = '{RST0, RST0, RUN};
      foreach (t[i]) begin
         exp_t e;
         drive(t[i], x[i], "reset");
         e = sb.pop_front();
         total++;
         if (ctl_o !== e.ctl) $display("FAIL %s[%0d] ctl got %b want %b", e.name, i, ctl_o, e.ctl); else passed++;
         total++;
         if (stall_cnt !== e.cnt) $display("FAIL %s[%0d] stall_cnt got %0d want %0d", e.name, i, stall_cnt, e.cnt); else passed++;
      end
   endtask

   task automatic test_ack_same();
      stim_t t[$];
      logic [10:0] x[$];
      t = '{S(1, 0, 1), S(), S(0, 1, 1), S()};
      x = '{RLI, RUN, RLI, RUN};
      foreach (t[i]) begin
         exp_t e;
         drive(t[i], x[i], "ack_same");
         e = sb.pop_front();
         total++;
         if (ctl_o !== e.ctl) $display("FAIL %s[%0d] ctl got %b want %b", e.name, i, ctl_o, e.ctl); else passed++;
         total++;
         if (stall_cnt !== e.cnt) $display("FAIL %s[%0d] stall_cnt got %0d want %0d", e.name, i, stall_cnt, e.cnt); else passed++;
      end
   endtask

   task automatic test_store_ack3();
      stim_t t[$];
      logic [10:0] x[$];
      t = '{S(0, 1), S(0, 1), S(0, 1), S(0, 1, 1), S()};
      x = '{MSI, MSW, MSW, RLW, RUN};
      foreach (t[i]) begin
         exp_t e;
         drive(t[i], x[i], "store_ack3");
         e = sb.pop_front();
         total++;
         if (ctl_o !== e.ctl) $display("FAIL %s[%0d] ctl got %b want %b", e.name, i, ctl_o, e.ctl); else passed++;
         total++;
         if (stall_cnt !== e.cnt) $display("FAIL %s[%0d] stall_cnt got %0d want %0d", e.name, i, stall_cnt, e.cnt); else passed++;
      end
   endtask

   task automatic test_timeout();
      stim_t t[$];
      logic [10:0] x[$];
      t = '{S(1), S(1), S(1), S(1), S(1), S(), S(0, 0, 0, 1), S(),
            S(1), S(1), S(1), S(1), S(1, 0, 1), S(),
            S(1, 0, 0, 1), S(1, 0, 0, 1), S(1, 0, 0, 1), S(1, 0, 0, 1), S(1, 0, 0, 1), S()};
      x = '{MSI, MSW, MSW, MSW, RLW, RUN, RUN, RUN,
            MSI, MSW, MSW, MSW, RLW, RUN,
            MSI, MSW, MSW, MSW, RLW, RUN};
      foreach (t[i]) begin
         exp_t e;
         drive(t[i], x[i], "timeout");
         if (i == 4 || i == 18) exp_err = 1;
         if (i == 6) exp_err = 0;
         e = sb.pop_front();
         total++;
         if (ctl_o !== e.ctl) $display("FAIL %s[%0d] ctl got %b want %b", e.name, i, ctl_o, e.ctl); else passed++;
         total++;
         if (stall_cnt !== e.cnt) $display("FAIL %s[%0d] stall_cnt got %0d want %0d", e.name, i, stall_cnt, e.cnt); else passed++;
      end
   endtask

   task automatic test_reset_mid_wait();
      stim_t t[$];
      logic [10:0] x[$];
      t = '{S(1), S(1), S(1), S(1, 0, 0, 0, 1),
            S(1), S(1), S(1), S(1), S(1), S(), S(0, 0, 0, 1), S()};
      x = '{MSI, MSW, MSW, RST0,
            MSI, MSW, MSW, MSW, RLW, RUN, RUN, RUN};
      foreach (t[i]) begin
         exp_t e;
         drive(t[i], x[i], "reset_mid_wait");
         if (i == 8) exp_err = 1;
         if (i == 10) exp_err = 0;
         e = sb.pop_front();
         total++;
         if (ctl_o !== e.ctl) $display("FAIL %s[%0d] ctl got %b want %b", e.name, i, ctl_o, e.ctl); else passed++;
         total++;
         if (stall_cnt !== e.cnt) $display("FAIL %s[%0d] stall_cnt got %0d want %0d", e.name, i, stall_cnt, e.cnt); else passed++;
      end
   endtask

   task automatic test_load_use();
      stim_t t[$];
      logic [10:0] x[$];
      t = '{S(0, 0, 0, 0, 0, 1, 5, 3, 5), S(), S(0, 0, 0, 0, 0, 1, 0, 0, 0),
            S(0, 0, 0, 0, 0, 1, 7, 7, 1), S(0, 0, 0, 0, 0, 0, 5, 5, 5), S(0, 0, 0, 0, 0, 1, 9, 3, 4)};
      x = '{LU, RUN, RUN, LU, RUN, RUN};
      foreach (t[i]) begin
         exp_t e;
         drive(t[i], x[i], "load_use");
         e = sb.pop_front();
         total++;
         if (ctl_o !== e.ctl) $display("FAIL %s[%0d] ctl got %b want %b", e.name, i, ctl_o, e.ctl); else passed++;
         total++;
         if (stall_cnt !== e.cnt) $display("FAIL %s[%0d] stall_cnt got %0d want %0d", e.name, i, stall_cnt, e.cnt); else passed++;
      end
   endtask

   task automatic test_branch();
      stim_t t[$];
      logic [10:0] x[$];
      t = '{S(0, 0, 0, 0, 0, 1, 5, 5, 0, 1), S(),
            S(1, 0, 0, 0, 0, 1, 5, 5, 0, 1), S(1, 0, 0, 0, 0, 1, 5, 5, 0, 1),
            S(1, 0, 1, 0, 0, 1, 5, 5, 0, 1), S()};
      x = '{BR, RUN, MSI, MSW, BRW, RUN};
      foreach (t[i]) begin
         exp_t e;
         drive(t[i], x[i], "branch");
         e = sb.pop_front();
         total++;
         if (ctl_o !== e.ctl) $display("FAIL %s[%0d] ctl got %b want %b", e.name, i, ctl_o, e.ctl); else passed++;
         total++;
         if (stall_cnt !== e.cnt) $display("FAIL %s[%0d] stall_cnt got %0d want %0d", e.name, i, stall_cnt, e.cnt); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      stim_t t[$];
      logic [10:0] x[$];
      t = '{S(1, 0, 1), S(0, 1, 1), S(1), S(1), S(1, 0, 1), S(0, 1), S(0, 1, 1), S()};
      x = '{RLI, RLI, MSI, MSW, RLW, MSI, RLW, RUN};
      foreach (t[i]) begin
         exp_t e;
         drive(t[i], x[i], "back_to_back");
         e = sb.pop_front();
         total++;
         if (ctl_o !== e.ctl) $display("FAIL %s[%0d] ctl got %b want %b", e.name, i, ctl_o, e.ctl); else passed++;
         total++;
         if (stall_cnt !== e.cnt) $display("FAIL %s[%0d] stall_cnt got %0d want %0d", e.name, i, stall_cnt, e.cnt); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_ack_same();
      test_store_ack3();
      test_timeout();
      test_reset_mid_wait();
      test_load_use();
      test_branch();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/pipe_mem_stall_ctrl.md
Name: pipe_mem_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Drives the en/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable.
- Runs a req/ack handshake with a multi-cycle data memory, with a timeout guard.
- Also resolves load-use stalls and taken-branch flushes, and keeps a stall-cycle counter.

Parameters:
- MAX_WAIT, 16: max cycles in WAIT without mem_ack before forced release and error; must be >= 1.
- CNT_W, 32: width of stall_cnt.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- MemRead_M  in  1  load in MEM stage (EX/MEM output)
- MemWrite_M  in  1  store in MEM stage
- mem_ack  in  1  data memory done; ignored while mem_req=0
- MemRead_E  in  1  load in EX stage
- Rd_E  in  5  destination register in EX
- Rs1_D  in  5  source register 1 in ID
- Rs2_D  in  5  source register 2 in ID
- PCSrc_E  in  1  taken branch/jump resolved in EX
- err_clr  in  1  clears mem_err
- mem_req  out  1  data memory request, held until ack/timeout
- en_PC  out  1  PC register enable
- en_FD  out  1  IF/ID enable
- en_DE  out  1  ID/EX enable
- en_EM  out  1  EX/MEM enable
- en_MW  out  1  MEM/WB enable
- flush_FD  out  1  IF/ID flush
- flush_DE  out  1  ID/EX flush
- flush_MW  out  1  MEM/WB flush (bubble into WB)
- mem_busy  out  1  high while in WAIT
- mem_err  out  1  sticky timeout flag
- stall_cnt  out  CNT_W  count of cycles with en_PC=0

Behaviour:
- FSM states: IDLE, WAIT. Registers: state, wait_cnt (clog2(MAX_WAIT+1) bits), mem_err, stall_cnt. All cleared by rst (state=IDLE), asynchronously.
- Control outputs are combinational (Mealy) from state and inputs. While rst is high: mem_req=0 and all en/flush outputs = 0.
- memop = MemRead_M | MemWrite_M.
- mem_req = (IDLE & memop) | WAIT.
- Memory release ("rel"):
  - rel = mem_req & (mem_ack | (WAIT & wait_cnt == MAX_WAIT-1)).
  - An ack in the same cycle as a memop in IDLE gives zero stall cycles.
- Memory stall: ms = mem_req & ~rel. While ms:
  - en_PC = en_FD = en_DE = en_EM = 0.
  - en_MW = 1 and flush_MW = 1, so WB gets a bubble (no duplicate RegWrite).
  - flush_FD = flush_DE = 0.
- Transitions:
  - IDLE→WAIT when memop & ~mem_ack; wait_cnt reset to 0.
  - WAIT: wait_cnt increments each cycle.
  - WAIT→IDLE on rel.
  - Timeout without ack sets mem_err; the pipeline is released, and ReadData is don't-care.
  - Ack and timeout in the same cycle: ack wins, mem_err is not set.
- After rel the pipe advances in that cycle. The next memop in MEM starts a fresh request the following cycle, with no idle gap required.
- Load-use hazard: lu = MemRead_E & (Rd_E != 0) & (Rd_E == Rs1_D | Rd_E == Rs2_D).
- Output priority when not ms:
  - PCSrc_E=1: all en=1, flush_FD=1, flush_DE=1, flush_MW=0. Branch overrides lu because the ID instruction is discarded.
  - else lu=1: en_PC=0, en_FD=0, en_DE=1 with flush_DE=1, en_EM=1, en_MW=1.
  - else: all en=1, all flush=0.
- Flush is only ever asserted together with en=1 on the same register.
- Priority order: ms > PCSrc_E > lu. While ms, PCSrc_E and lu are held because the EX/ID contents are frozen, and they take effect after release.
- mem_err:
  - Set on timeout.
  - Cleared by err_clr unless a timeout occurs in the same cycle (set wins).
- stall_cnt:
  - Increments every cycle with rst=0 and en_PC=0; wraps at 2^CNT_W.
  - Cleared only by rst.
- Reset mid-WAIT: state returns to IDLE immediately and mem_req drops while rst is high. After rst deasserts, a pending memop issues a fresh request.
- mem_busy = (state == WAIT).

Test Plan:
- Load in MEM with mem_ack high the same cycle → mem_req=1 for 1 cycle, all en=1, stall_cnt unchanged, state stays IDLE.
- Store in MEM, mem_ack asserted 3 cycles after first mem_req:
  - en_PC..en_EM=0 and flush_MW=1 for exactly 3 cycles, then all en=1.
  - mem_busy high 3 cycles; stall_cnt=3.
- MAX_WAIT=4, mem_ack never asserted:
  - Release in the 5th req cycle (IDLE cycle plus 4 WAIT cycles), mem_err=1.
  - A following err_clr pulse brings mem_err to 0.
  - Ack arriving exactly on the timeout cycle → mem_err stays 0.
- MemRead_E=1, Rd_E=5, Rs2_D=5 → en_PC=0, en_FD=0, flush_DE=1 for 1 cycle.
  - Rd_E=0 with Rs1_D=0 → no stall.
- PCSrc_E=1 together with lu=1 → flush_FD=1, flush_DE=1, en_PC=1.
  - Same inputs during an active memory stall → no flush until the cycle of mem_ack.
- rst asserted during WAIT with wait_cnt=2:
  - mem_req, en_*, mem_err and stall_cnt all go to 0 immediately.
  - After release, memop held high → new mem_req the next cycle, wait_cnt restarts at 0.
